operand_forward_unit: RTL and testbench
=======================================

Name: operand_forward_unit

Overview:
- Parametrised operand bypass and load-use hazard unit for the EX stage of the pipelined core. It generalises the two-input forwarding mux to NUM_SRC source operands and adds a HIST_DEPTH-entry retired-write history, so the register file no longer needs write-through.
- It contains a load-use stall FSM that holds ID for LOAD_LAT cycles.
- It sits between the ID/EX, EX/MEM and MEM/WB pipeline registers and drives the ALU operand inputs plus the pipeline stall/bubble controls.

Parameters:
XLEN, 32, datapath width
NUM_SRC, 2, source operands per instruction (1..4)
REG_AW, 5, register address width
HIST_DEPTH, 1, retired-write history entries (0..4); 0 removes the history
LOAD_LAT, 1, stall cycles per load-use hazard (1..3)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ex_rs_addr  in  NUM_SRC*REG_AW  EX-stage source register addresses; operand i is at slice i
ex_rs_data  in  NUM_SRC*XLEN  register-file values carried in ID/EX
ex_valid  in  1  EX holds a real instruction
ex_rd_addr  in  REG_AW  EX destination register
ex_regwrite  in  1  EX instruction writes a register
ex_memread  in  1  EX instruction is a load
id_rs_addr  in  NUM_SRC*REG_AW  ID-stage source addresses
id_valid  in  1  ID holds a real instruction
mem_rd_addr  in  REG_AW  EX/MEM destination register
mem_regwrite  in  1  EX/MEM writes a register
mem_memread  in  1  EX/MEM is a load
mem_alu_result  in  XLEN  EX/MEM ALU result
wb_rd_addr  in  REG_AW  MEM/WB destination register
wb_regwrite  in  1  MEM/WB writes a register
wb_data  in  XLEN  write-back value
fwd_data_o  out  NUM_SRC*XLEN  forwarded operands
fwd_sel_o  out  NUM_SRC*3  per-operand source code: 0=regfile, 1=MEM, 2=WB, 3+k=history entry k
stall_o  out  1  freeze PC and IF/ID
bubble_o  out  1  zero the ID/EX control signals

Behaviour:
- Reset (rst_n low, async): history valid bits cleared, FSM to IDLE, counter to 0, stall_o=0, bubble_o=0. fwd_data_o stays combinational and falls back to regfile/MEM/WB selection.
- Forwarding is combinational with zero latency. Each operand i is resolved independently by priority:
  - 1. MEM: mem_regwrite && !mem_memread && mem_rd_addr==rs_i
  - 2. WB: wb_regwrite && wb_rd_addr==rs_i
  - 3. History entries, newest (k=0) first: valid && addr==rs_i
  - 4. ex_rs_data slice i
- rs_i==0 always selects the regfile value with sel=0; register x0 is never forwarded.
- A load in MEM is never a forwarding source. If its destination matches, selection falls through to lower priorities; the stall FSM guarantees this case does not occur.
- History is a shift register updated on the clock edge when wb_regwrite && wb_rd_addr!=0:
  - entry0 <= {wb_rd_addr, wb_data}, and entry k <= entry k-1.
  - On any other cycle it holds.
  - It is never cleared except by reset.
- Hazard term: hz = ex_valid && ex_memread && ex_regwrite && ex_rd_addr!=0 && id_valid && (any id_rs_i==ex_rd_addr, i<NUM_SRC).
- FSM:
  - IDLE: stall_o=bubble_o=hz. If hz && LOAD_LAT>1, go to STALL with cnt=LOAD_LAT-1.
  - STALL: stall_o=bubble_o=1 and cnt decrements each cycle. When cnt reaches 1, return to IDLE at the next edge. hz is ignored while in STALL.
- The total stall therefore equals exactly LOAD_LAT cycles per hazard. Back-to-back loads in consecutive instructions each produce their own stall window.
- A reset during STALL aborts the window immediately, and stall_o falls asynchronously.
- Simultaneous MEM and WB matches on the same register select MEM (the newer value).
- Simultaneous history shift and a lookup on the same cycle: the lookup uses the pre-edge contents, and the WB path covers the newest write.

Decomposition:
- Shared package: the fwd_sel encodings (FWD_RF, FWD_MEM, FWD_WB, FWD_HIST_BASE) and the FSM state typedef {IDLE, STALL}.
- One sub-module, fwd_operand_sel: the priority selector for a single operand, instantiated NUM_SRC times by a generate loop.
- The history register and the FSM stay in the top module.

Test Plan:
- MEM forward: mem_regwrite=1, mem_rd=5, mem_alu_result=0x0000_00AA, ex_rs0=5, ex_rs_data0=0x11 -> fwd_data0=0xAA, sel0=1; operand 1 is unaffected.
- Priority: MEM writes r7=0x1, WB writes r7=0x2, and history holds r7=0x3 -> result 0x1. Drop the MEM write -> 0x2. Drop the WB write -> 0x3 with sel=3.
- x0 guard: MEM and WB both write r0=0xFFFF_FFFF, ex_rs0=0 -> fwd_data0=ex_rs_data0, sel0=0.
- Load-use with LOAD_LAT=2: EX load to r9, ID reads r9 -> stall_o and bubble_o high for exactly 2 cycles, then low. With the ID operand changed to r10 -> no stall.
- History with HIST_DEPTH=2: write r3=0x33 then r4=0x44 through WB, clear WB, ex_rs0=3 -> 0x33, sel=4; ex_rs1=4 -> 0x44, sel=3.
- Reset mid-stall: assert rst_n=0 during the second STALL cycle -> stall_o=0 immediately and history empty; after release, with no hazard present, stall_o stays 0.

Source files
------------

// File: rtl/operand_forward_unit_pkg.sv
// ---------------------------------------------------------------------------
// operand_forward_unit_pkg
//
// Shared definitions for the EX-stage operand bypass unit:
//   - fwd_sel encodings reported per operand on fwd_sel_o
//   - the load-use stall FSM state type
//   - a helper that sizes the history storage so that HIST_DEPTH=0 still
//     elaborates (storage collapses to one unused slot)
// ---------------------------------------------------------------------------
package operand_forward_unit_pkg;

    // Per-operand source code. History entry k reports FWD_HIST_BASE + k.
    localparam logic [2:0] FWD_RF        = 3'd0;
    localparam logic [2:0] FWD_MEM       = 3'd1;
    localparam logic [2:0] FWD_WB        = 3'd2;
    localparam logic [2:0] FWD_HIST_BASE = 3'd3;

    // Width of one fwd_sel field.
    localparam int FWD_SEL_W = 3;

    // Width of the load-use stall counter (LOAD_LAT is at most 3).
    localparam int STALL_CNT_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } fsm_state_t;

    // Number of physical history slots; a zero-depth history keeps a single
    // slot whose valid bit is tied low so no port becomes zero-width.
    function automatic int hist_slots(input int depth);
        return (depth > 0) ? depth : 1;
    endfunction

endpackage

// File: rtl/operand_forward_unit_fwd_operand_sel.sv
// ---------------------------------------------------------------------------
// fwd_operand_sel
//
// Priority selector for a single EX-stage source operand. Picks, in order:
// EX/MEM ALU result (non-load only), MEM/WB write-back value, retired-write
// history entries newest first, and finally the register-file value carried
// in ID/EX. Register x0 always takes the register-file value.
//
// Ports:
//   rs_addr        in   REG_AW          source register of this operand
//   rf_data        in   XLEN            register-file value from ID/EX
//   mem_rd_addr    in   REG_AW          EX/MEM destination
//   mem_regwrite   in   1               EX/MEM writes a register
//   mem_memread    in   1               EX/MEM is a load (not forwardable)
//   mem_alu_result in   XLEN            EX/MEM ALU result
//   wb_rd_addr     in   REG_AW          MEM/WB destination
//   wb_regwrite    in   1               MEM/WB writes a register
//   wb_data        in   XLEN            write-back value
//   hist_valid     in   HW              history valid bits, entry 0 newest
//   hist_addr      in   HW*REG_AW       history destination addresses
//   hist_data      in   HW*XLEN         history data
//   fwd_data       out  XLEN            resolved operand
//   fwd_sel        out  3               source code of the resolved operand
// ---------------------------------------------------------------------------
module fwd_operand_sel
    import operand_forward_unit_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_AW     = 5,
    parameter int HIST_DEPTH = 1,
    parameter int HW         = hist_slots(HIST_DEPTH)
) (
    input  logic [REG_AW-1:0]    rs_addr,
    input  logic [XLEN-1:0]      rf_data,
    input  logic [REG_AW-1:0]    mem_rd_addr,
    input  logic                 mem_regwrite,
    input  logic                 mem_memread,
    input  logic [XLEN-1:0]      mem_alu_result,
    input  logic [REG_AW-1:0]    wb_rd_addr,
    input  logic                 wb_regwrite,
    input  logic [XLEN-1:0]      wb_data,
    input  logic [HW-1:0]        hist_valid,
    input  logic [HW*REG_AW-1:0] hist_addr,
    input  logic [HW*XLEN-1:0]   hist_data,
    output logic [XLEN-1:0]      fwd_data,
    output logic [2:0]           fwd_sel
);

    logic mem_hit;
    logic wb_hit;
    logic hist_hit;

    assign mem_hit = mem_regwrite && !mem_memread && (mem_rd_addr == rs_addr);
    assign wb_hit  = wb_regwrite && (wb_rd_addr == rs_addr);

    // A load sitting in MEM is simply not a candidate; if its destination
    // matches, the lower-priority sources are consulted instead.
    always_comb begin
        fwd_data = rf_data;
        fwd_sel  = FWD_RF;
        hist_hit = 1'b0;
        if (rs_addr != '0) begin
            if (mem_hit) begin
                fwd_data = mem_alu_result;
                fwd_sel  = FWD_MEM;
            end else if (wb_hit) begin
                fwd_data = wb_data;
                fwd_sel  = FWD_WB;
            end else begin
                // Newest entry wins: stop looking after the first match.
                for (int k = 0; k < HIST_DEPTH; k++) begin
                    if (!hist_hit && hist_valid[k] &&
                        (hist_addr[k*REG_AW +: REG_AW] == rs_addr)) begin
                        hist_hit = 1'b1;
                        fwd_data = hist_data[k*XLEN +: XLEN];
                        fwd_sel  = FWD_HIST_BASE + 3'(k);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/operand_forward_unit.sv
// ---------------------------------------------------------------------------
// operand_forward_unit
//
// EX-stage operand bypass and load-use hazard unit. Resolves NUM_SRC source
// operands combinationally from EX/MEM, MEM/WB and a HIST_DEPTH-entry history
// of retired writes (so the register file needs no write-through), and holds
// ID for LOAD_LAT cycles whenever the instruction in ID consumes the result
// of a load currently in EX.
//
// Ports:
//   clk            in   1                clock, rising edge
//   rst_n          in   1                asynchronous active-low reset
//   ex_rs_addr     in   NUM_SRC*REG_AW   EX source addresses, operand i at slice i
//   ex_rs_data     in   NUM_SRC*XLEN     register-file values from ID/EX
//   ex_valid       in   1                EX holds a real instruction
//   ex_rd_addr     in   REG_AW           EX destination register
//   ex_regwrite    in   1                EX writes a register
//   ex_memread     in   1                EX is a load
//   id_rs_addr     in   NUM_SRC*REG_AW   ID source addresses
//   id_valid       in   1                ID holds a real instruction
//   mem_rd_addr    in   REG_AW           EX/MEM destination
//   mem_regwrite   in   1                EX/MEM writes a register
//   mem_memread    in   1                EX/MEM is a load
//   mem_alu_result in   XLEN             EX/MEM ALU result
//   wb_rd_addr     in   REG_AW           MEM/WB destination
//   wb_regwrite    in   1                MEM/WB writes a register
//   wb_data        in   XLEN             write-back value
//   fwd_data_o     out  NUM_SRC*XLEN     forwarded operands
//   fwd_sel_o      out  NUM_SRC*3        per-operand source code
//   stall_o        out  1                freeze PC and IF/ID
//   bubble_o       out  1                zero the ID/EX control signals
// ---------------------------------------------------------------------------
module operand_forward_unit
    import operand_forward_unit_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NUM_SRC    = 2,
    parameter int REG_AW     = 5,
    parameter int HIST_DEPTH = 1,
    parameter int LOAD_LAT   = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_SRC*REG_AW-1:0]   ex_rs_addr,
    input  logic [NUM_SRC*XLEN-1:0]     ex_rs_data,
    input  logic                        ex_valid,
    input  logic [REG_AW-1:0]           ex_rd_addr,
    input  logic                        ex_regwrite,
    input  logic                        ex_memread,
    input  logic [NUM_SRC*REG_AW-1:0]   id_rs_addr,
    input  logic                        id_valid,
    input  logic [REG_AW-1:0]           mem_rd_addr,
    input  logic                        mem_regwrite,
    input  logic                        mem_memread,
    input  logic [XLEN-1:0]             mem_alu_result,
    input  logic [REG_AW-1:0]           wb_rd_addr,
    input  logic                        wb_regwrite,
    input  logic [XLEN-1:0]             wb_data,
    output logic [NUM_SRC*XLEN-1:0]     fwd_data_o,
    output logic [NUM_SRC*FWD_SEL_W-1:0] fwd_sel_o,
    output logic                        stall_o,
    output logic                        bubble_o
);

    localparam int HW = hist_slots(HIST_DEPTH);
    localparam logic [STALL_CNT_W-1:0] CNT_INIT = STALL_CNT_W'(LOAD_LAT - 1);

    // -----------------------------------------------------------------------
    // Retired-write history, entry 0 newest. Packed 2-D so each array is
    // bit-identical to the flattened selector ports.
    // -----------------------------------------------------------------------
    logic [HW-1:0]              hist_valid;
    logic [HW-1:0][REG_AW-1:0]  hist_addr;
    logic [HW-1:0][XLEN-1:0]    hist_data;

    generate
        if (HIST_DEPTH > 0) begin : g_hist
            // Shifts only on a real register write; writes to x0 are dropped
            // because x0 is never a forwarding target.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hist_valid <= '0;
                    hist_addr  <= '0;
                    hist_data  <= '0;
                end else if (wb_regwrite && (wb_rd_addr != '0)) begin
                    hist_valid[0] <= 1'b1;
                    hist_addr[0]  <= wb_rd_addr;
                    hist_data[0]  <= wb_data;
                    for (int k = 1; k < HIST_DEPTH; k++) begin
                        hist_valid[k] <= hist_valid[k-1];
                        hist_addr[k]  <= hist_addr[k-1];
                        hist_data[k]  <= hist_data[k-1];
                    end
                end
            end
        end else begin : g_no_hist
            assign hist_valid = '0;
            assign hist_addr  = '0;
            assign hist_data  = '0;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // One independent priority selector per source operand. Lookups see the
    // pre-edge history; a write retiring this cycle is covered by the WB path.
    // -----------------------------------------------------------------------
    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
            fwd_operand_sel #(
                .XLEN       (XLEN),
                .REG_AW     (REG_AW),
                .HIST_DEPTH (HIST_DEPTH),
                .HW         (HW)
            ) u_sel (
                .rs_addr        (ex_rs_addr[i*REG_AW +: REG_AW]),
                .rf_data        (ex_rs_data[i*XLEN +: XLEN]),
                .mem_rd_addr    (mem_rd_addr),
                .mem_regwrite   (mem_regwrite),
                .mem_memread    (mem_memread),
                .mem_alu_result (mem_alu_result),
                .wb_rd_addr     (wb_rd_addr),
                .wb_regwrite    (wb_regwrite),
                .wb_data        (wb_data),
                .hist_valid     (hist_valid),
                .hist_addr      (hist_addr),
                .hist_data      (hist_data),
                .fwd_data       (fwd_data_o[i*XLEN +: XLEN]),
                .fwd_sel        (fwd_sel_o[i*FWD_SEL_W +: FWD_SEL_W])
            );
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Load-use hazard: a load in EX whose destination feeds any ID operand.
    // -----------------------------------------------------------------------
    logic id_match;
    logic hz;

    always_comb begin
        id_match = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_rs_addr[i*REG_AW +: REG_AW] == ex_rd_addr) begin
                id_match = 1'b1;
            end
        end
    end

    assign hz = ex_valid && ex_memread && ex_regwrite &&
                (ex_rd_addr != '0) && id_valid && id_match;

    // -----------------------------------------------------------------------
    // Stall FSM. The hazard cycle itself (in IDLE) is the first stall cycle;
    // STALL supplies the remaining LOAD_LAT-1 cycles, ignoring hz meanwhile.
    // -----------------------------------------------------------------------
    fsm_state_t                 state;
    fsm_state_t                 state_next;
    logic [STALL_CNT_W-1:0]     cnt;
    logic [STALL_CNT_W-1:0]     cnt_next;
    logic                       stall_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        stall_raw  = 1'b0;
        case (state)
            IDLE: begin
                stall_raw = hz;
                if (hz && (LOAD_LAT > 1)) begin
                    state_next = STALL;
                    cnt_next   = CNT_INIT;
                end
            end
            STALL: begin
                stall_raw = 1'b1;
                if (cnt <= STALL_CNT_W'(1)) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - STALL_CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // The hazard term is purely combinational, so it is masked while reset
    // is held to keep the pipeline controls quiet throughout reset.
    assign stall_o  = stall_raw & rst_n;
    assign bubble_o = stall_raw & rst_n;

endmodule

// File: tb/tb_operand_forward_unit.sv
// ---------------------------------------------------------------------------
// tb_operand_forward_unit
//
// Directed, table-driven bench for operand_forward_unit configured with
// NUM_SRC=2, HIST_DEPTH=2, LOAD_LAT=2. Forwarding vectors live in a table of
// {inputs, expected outputs}; load-use and reset-mid-stall are hand-written
// sequences.
// ---------------------------------------------------------------------------
module tb_operand_forward_unit;

    localparam int XLEN       = 32;
    localparam int NUM_SRC    = 2;
    localparam int REG_AW     = 5;
    localparam int HIST_DEPTH = 2;
    localparam int LOAD_LAT   = 2;
    localparam int NVEC       = 13;

    logic                       clk;
    logic                       rst_n;
    logic [NUM_SRC*REG_AW-1:0]  ex_rs_addr;
    logic [NUM_SRC*XLEN-1:0]    ex_rs_data;
    logic                       ex_valid;
    logic [REG_AW-1:0]          ex_rd_addr;
    logic                       ex_regwrite;
    logic                       ex_memread;
    logic [NUM_SRC*REG_AW-1:0]  id_rs_addr;
    logic                       id_valid;
    logic [REG_AW-1:0]          mem_rd_addr;
    logic                       mem_regwrite;
    logic                       mem_memread;
    logic [XLEN-1:0]            mem_alu_result;
    logic [REG_AW-1:0]          wb_rd_addr;
    logic                       wb_regwrite;
    logic [XLEN-1:0]            wb_data;
    logic [NUM_SRC*XLEN-1:0]    fwd_data_o;
    logic [NUM_SRC*3-1:0]       fwd_sel_o;
    logic                       stall_o;
    logic                       bubble_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic        pre_we;
        logic [4:0]  pre_rd;
        logic [31:0] pre_dat;
        logic        mem_we;
        logic        mem_ld;
        logic [4:0]  mem_rd;
        logic [31:0] mem_res;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_dat;
        logic [4:0]  rs0;
        logic [31:0] d0;
        logic [4:0]  rs1;
        logic [31:0] d1;
        logic [31:0] e0;
        logic [2:0]  s0;
        logic [31:0] e1;
        logic [2:0]  s1;
    } vec_t;

    vec_t vecs [NVEC];

    operand_forward_unit #(
        .XLEN       (XLEN),
        .NUM_SRC    (NUM_SRC),
        .REG_AW     (REG_AW),
        .HIST_DEPTH (HIST_DEPTH),
        .LOAD_LAT   (LOAD_LAT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_rs_addr     (ex_rs_addr),
        .ex_rs_data     (ex_rs_data),
        .ex_valid       (ex_valid),
        .ex_rd_addr     (ex_rd_addr),
        .ex_regwrite    (ex_regwrite),
        .ex_memread     (ex_memread),
        .id_rs_addr     (id_rs_addr),
        .id_valid       (id_valid),
        .mem_rd_addr    (mem_rd_addr),
        .mem_regwrite   (mem_regwrite),
        .mem_memread    (mem_memread),
        .mem_alu_result (mem_alu_result),
        .wb_rd_addr     (wb_rd_addr),
        .wb_regwrite    (wb_regwrite),
        .wb_data        (wb_data),
        .fwd_data_o     (fwd_data_o),
        .fwd_sel_o      (fwd_sel_o),
        .stall_o        (stall_o),
        .bubble_o       (bubble_o)
    );

    // Rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic checkStall(input string name, input logic exp);
        checkOutput({name, "_stall"},  {31'b0, stall_o},  {31'b0, exp});
        checkOutput({name, "_bubble"}, {31'b0, bubble_o}, {31'b0, exp});
    endtask

    task automatic clearFwd();
        mem_regwrite   = 1'b0;
        mem_memread    = 1'b0;
        mem_rd_addr    = '0;
        mem_alu_result = '0;
        wb_regwrite    = 1'b0;
        wb_rd_addr     = '0;
        wb_data        = '0;
    endtask

    task automatic clearHazard();
        ex_valid    = 1'b0;
        ex_memread  = 1'b0;
        ex_regwrite = 1'b0;
        ex_rd_addr  = '0;
        id_valid    = 1'b0;
        id_rs_addr  = '0;
    endtask

    // Called just after a rising edge; an optional history preload consumes
    // one edge, and the vector itself is applied and released before the
    // next edge so only preloads ever shift the history.
    task automatic applyStimulus(input vec_t v);
        if (v.pre_we) begin
            clearFwd();
            wb_regwrite = 1'b1;
            wb_rd_addr  = v.pre_rd;
            wb_data     = v.pre_dat;
            @(posedge clk);
            #1;
            wb_regwrite = 1'b0;
        end
        mem_regwrite   = v.mem_we;
        mem_memread    = v.mem_ld;
        mem_rd_addr    = v.mem_rd;
        mem_alu_result = v.mem_res;
        wb_regwrite    = v.wb_we;
        wb_rd_addr     = v.wb_rd;
        wb_data        = v.wb_dat;
        ex_rs_addr     = {v.rs1, v.rs0};
        ex_rs_data     = {v.d1, v.d0};
    endtask

    initial begin
        // name, pre_we/rd/dat, mem_we/ld/rd/res, wb_we/rd/dat,
        // rs0, d0, rs1, d1, e0, s0, e1, s1
        vecs[0]  = '{"mem_fwd",      0, 0, 0,          1, 0, 5, 32'hAA,       0, 0, 0,
                     5, 32'h11, 6, 32'h22, 32'hAA, 3'd1, 32'h22, 3'd0};
        vecs[1]  = '{"wb_fwd",       0, 0, 0,          0, 0, 0, 0,            1, 6, 32'h66,
                     5, 32'h11, 6, 32'h22, 32'h11, 3'd0, 32'h66, 3'd2};
        vecs[2]  = '{"x0_guard",     0, 0, 0,          1, 0, 0, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF,
                     0, 32'h1234, 0, 32'h5678, 32'h1234, 3'd0, 32'h5678, 3'd0};
        vecs[3]  = '{"load_no_fwd",  0, 0, 0,          1, 1, 8, 32'hBAD,      1, 9, 32'h99,
                     8, 32'h88, 9, 32'h0, 32'h88, 3'd0, 32'h99, 3'd2};
        vecs[4]  = '{"load_to_wb",   0, 0, 0,          1, 1, 8, 32'hBAD,      1, 8, 32'h77,
                     8, 32'h88, 2, 32'h22, 32'h77, 3'd2, 32'h22, 3'd0};
        vecs[5]  = '{"mem_over_wb",  1, 7, 32'h3,      1, 0, 7, 32'h1,        1, 7, 32'h2,
                     7, 32'h70, 7, 32'h71, 32'h1, 3'd1, 32'h1, 3'd1};
        vecs[6]  = '{"wb_over_hist", 0, 0, 0,          0, 0, 0, 0,            1, 7, 32'h2,
                     7, 32'h70, 1, 32'h10, 32'h2, 3'd2, 32'h10, 3'd0};
        vecs[7]  = '{"hist_hit",     0, 0, 0,          0, 0, 0, 0,            0, 0, 0,
                     7, 32'h70, 0, 32'h5, 32'h3, 3'd3, 32'h5, 3'd0};
        vecs[8]  = '{"hist_two",     1, 3, 32'h33,     0, 0, 0, 0,            0, 0, 0,
                     7, 32'h70, 3, 32'h30, 32'h3, 3'd4, 32'h33, 3'd3};
        vecs[9]  = '{"hist_depth",   1, 4, 32'h44,     0, 0, 0, 0,            0, 0, 0,
                     3, 32'h30, 4, 32'h40, 32'h33, 3'd4, 32'h44, 3'd3};
        vecs[10] = '{"hist_evict",   0, 0, 0,          1, 0, 4, 32'hA4,       0, 0, 0,
                     7, 32'h70, 4, 32'h40, 32'h70, 3'd0, 32'hA4, 3'd1};
        vecs[11] = '{"load_to_hist", 0, 0, 0,          1, 1, 3, 32'hBAD,      0, 0, 0,
                     3, 32'h30, 0, 32'h9, 32'h33, 3'd4, 32'h9, 3'd0};
        vecs[12] = '{"x0_no_shift",  1, 0, 32'hDEAD,   0, 0, 0, 0,            0, 0, 0,
                     3, 32'h30, 4, 32'h40, 32'h33, 3'd4, 32'h44, 3'd3};

        // Reset state: controls low, operands fall back to the register file.
        rst_n = 1'b0;
        clearFwd();
        clearHazard();
        ex_rs_addr = {5'd3, 5'd7};
        ex_rs_data = {32'h0000_0030, 32'h0000_0070};
        #1;
        checkStall("reset", 1'b0);
        checkOutput("reset_d0",   fwd_data_o[31:0], 32'h70);
        checkOutput("reset_sel0", {29'b0, fwd_sel_o[2:0]}, 32'd0);
        #11;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] forwarding vectors");
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            #2;
            checkOutput({vecs[i].name, "_d0"},   fwd_data_o[31:0],  vecs[i].e0);
            checkOutput({vecs[i].name, "_sel0"}, {29'b0, fwd_sel_o[2:0]}, {29'b0, vecs[i].s0});
            checkOutput({vecs[i].name, "_d1"},   fwd_data_o[63:32], vecs[i].e1);
            checkOutput({vecs[i].name, "_sel1"}, {29'b0, fwd_sel_o[5:3]}, {29'b0, vecs[i].s1});
            clearFwd();
            @(posedge clk);
            #1;
        end

        $display("[TB] load-use sequences");
        // Load to r9 in EX, ID reads r9: two stall cycles, then released.
        ex_valid = 1'b1; ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd_addr = 5'd9;
        id_valid = 1'b1; id_rs_addr = {5'd2, 5'd9};
        #1;
        checkStall("lu_c0", 1'b1);
        @(posedge clk);
        #1;
        clearHazard();
        #1;
        checkStall("lu_c1", 1'b1);
        @(posedge clk);
        #1;
        checkStall("lu_c2", 1'b0);
        @(posedge clk);
        #1;
        checkStall("lu_c3", 1'b0);

        // Same load, ID reads r10/r11: no hazard.
        ex_valid = 1'b1; ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd_addr = 5'd9;
        id_valid = 1'b1; id_rs_addr = {5'd11, 5'd10};
        #1;
        checkStall("lu_nomatch", 1'b0);
        @(posedge clk);
        #1;
        checkStall("lu_nomatch_c1", 1'b0);

        // Match on operand 1 opens a fresh window of its own.
        id_rs_addr = {5'd9, 5'd3};
        #1;
        checkStall("lu_op1_c0", 1'b1);
        @(posedge clk);
        #1;
        clearHazard();
        #1;
        checkStall("lu_op1_c1", 1'b1);
        @(posedge clk);
        #1;
        checkStall("lu_op1_c2", 1'b0);

        // Load to r0 never stalls.
        ex_valid = 1'b1; ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd_addr = 5'd0;
        id_valid = 1'b1; id_rs_addr = {5'd0, 5'd0};
        #1;
        checkStall("lu_x0", 1'b0);
        clearHazard();
        @(posedge clk);
        #1;

        $display("[TB] reset during stall");
        ex_valid = 1'b1; ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd_addr = 5'd12;
        id_valid = 1'b1; id_rs_addr = {5'd1, 5'd12};
        #1;
        checkStall("rst_c0", 1'b1);
        @(posedge clk);
        #1;
        clearHazard();
        #1;
        checkStall("rst_c1", 1'b1);
        rst_n = 1'b0;
        #1;
        checkStall("rst_abort", 1'b0);
        // History held r4/r3 before reset; both must now come from the regfile.
        clearFwd();
        ex_rs_addr = {5'd3, 5'd4};
        ex_rs_data = {32'h0000_0030, 32'h0000_0040};
        #1;
        checkOutput("rst_hist_d0",   fwd_data_o[31:0],  32'h40);
        checkOutput("rst_hist_sel0", {29'b0, fwd_sel_o[2:0]}, 32'd0);
        checkOutput("rst_hist_d1",   fwd_data_o[63:32], 32'h30);
        checkOutput("rst_hist_sel1", {29'b0, fwd_sel_o[5:3]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checkStall("post_rst", 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
